// File: rtl/sr_flag_pkg.sv
// Shared types and constants for the SR-flag arbiter.
//   state_t    : arbiter FSM states (IDLE, APPLY)
//   OP_SET     : requester op code that sets a flag
//   OP_CLR     : requester op code that clears a flag
//   NOOP_CNT_W : width of the saturating no-op counter
//   idx_width  : index width for n items, never less than 1
package sr_flag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  localparam int unsigned NOOP_CNT_W = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_cell.sv
// One SR flag cell: R clears, S sets, neither holds.
// The arbiter never drives S and R together; R wins if it ever did.
// Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous active-low reset (Q -> 0)
//   S     in  set request
//   R     in  clear request
//   Q     out stored flag value
module sr_cell (
  input  logic clk,
  input  logic reset,
  input  logic S,
  input  logic R,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (!reset)  Q <= 1'b0;
    else if (R)  Q <= 1'b0;
    else if (S)  Q <= 1'b1;
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that owns a bank of NFLAG SR flag cells and serves
// set/clear requests from NREQ requesters, one operation per two cycles.
// Optional feature macro: NOOP_DETECT_EN (adds noop / noop_cnt outputs).
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-low reset
//   req      in   [NREQ]     per-requester request, held until grant seen
//   op_set   in   [NREQ]     per-requester op (1 = set, 0 = clear)
//   idx      in   [NREQ*FW]  per-requester flag index, requester i at [i*FW +: FW]
//   clr_all  in   clear every flag at the next edge, overrides any op
//   gnt      out  [NREQ]     one-hot grant pulse, high during APPLY
//   busy     out  high during APPLY
//   flags    out  [NFLAG]    flag cell outputs
//   noop     out  (NOOP_DETECT_EN) APPLY cycle whose op changes nothing
//   noop_cnt out  [8] (NOOP_DETECT_EN) saturating count of noop pulses
module sr_flag_arbiter
  import sr_flag_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NFLAG = 8,
  parameter int unsigned FW    = idx_width(NFLAG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op_set,
  input  logic [NREQ*FW-1:0]   idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [NFLAG-1:0]     flags
`ifdef NOOP_DETECT_EN
  ,
  output logic                 noop,
  output logic [NOOP_CNT_W-1:0] noop_cnt
`endif
);

  localparam int unsigned RW = idx_width(NREQ);

  state_t          r_state;
  logic [RW-1:0]   r_rr_ptr;
  logic [RW-1:0]   r_win;
  logic            r_op;
  logic [FW-1:0]   r_idx;
  logic [NREQ-1:0] r_gnt;
  logic            r_busy;

  logic [2*NREQ-1:0] w_req_rot;
  logic              w_any;
  logic [RW-1:0]     w_pick;
  logic              w_op;
  logic [FW-1:0]     w_idx;
  logic              w_apply;
  logic [NFLAG-1:0]  w_sel;
  logic [NFLAG-1:0]  w_set;
  logic [NFLAG-1:0]  w_rst;

  // Round-robin pick: rotate req so rr_ptr lands at bit 0, take the first set bit.
  always_comb begin
    int unsigned pos;
    w_any     = 1'b0;
    w_pick    = '0;
    pos       = 0;
    w_req_rot = {req, req} >> r_rr_ptr;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!w_any && w_req_rot[k]) begin
        w_any = 1'b1;
        pos   = int'(r_rr_ptr) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        w_pick = RW'(pos);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_op  = OP_CLR;
    w_idx = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (w_pick == RW'(k)) begin
        w_op  = op_set[k];
        w_idx = idx[k*FW +: FW];
      end
    end
  end

  // Arbiter FSM; grant and busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_win    <= '0;
      r_op     <= OP_CLR;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt  <= '0;
          r_busy <= 1'b0;
          if (w_any) begin
            r_state <= APPLY;
            r_win   <= w_pick;
            r_op    <= w_op;
            r_idx   <= w_idx;
            r_gnt   <= NREQ'(1) << w_pick;
            r_busy  <= 1'b1;
          end
        end
        APPLY: begin
          r_state  <= IDLE;
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= (r_win == RW'(NREQ - 1)) ? '0 : r_win + RW'(1);
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign w_apply = (r_state == APPLY);

  // Cell drive: S needs an APPLY set without clr_all, so S and R are exclusive.
  // An out-of-range index matches no cell, leaving the bank untouched.
  always_comb begin
    w_sel = '0;
    w_set = '0;
    w_rst = '0;
    for (int i = 0; i < int'(NFLAG); i++) begin
      w_sel[i] = (r_idx == FW'(i));
      w_set[i] = w_apply && !clr_all && (r_op == OP_SET) && w_sel[i];
      w_rst[i] = clr_all || (w_apply && (r_op == OP_CLR) && w_sel[i]);
    end
  end

  for (genvar g = 0; g < int'(NFLAG); g++) begin : g_cell
    sr_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .S     (w_set[g]),
      .R     (w_rst[g]),
      .Q     (flags[g])
    );
  end

`ifdef NOOP_DETECT_EN
  logic                  w_in_range;
  logic                  w_cur;
  logic [NOOP_CNT_W-1:0] r_noop_cnt;

  assign w_in_range = |w_sel;
  assign w_cur      = |(w_sel & flags);

  // Decided in the APPLY cycle itself since clr_all may arrive then.
  assign noop = w_apply &&
                (clr_all || !w_in_range || ((r_op == OP_SET) ? w_cur : !w_cur));

  always_ff @(posedge clk) begin
    if (!reset)                         r_noop_cnt <= '0;
    else if (noop && (r_noop_cnt != '1)) r_noop_cnt <= r_noop_cnt + NOOP_CNT_W'(1);
  end

  assign noop_cnt = r_noop_cnt;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter (NREQ=4, NFLAG=8).
module tb_sr_flag_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned NFLAG = 8;
  localparam int unsigned FW    = 3;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   op_set;
  logic [NREQ*FW-1:0] idx;
  logic              clr_all;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [NFLAG-1:0]  flags;
`ifdef NOOP_DETECT_EN
  logic              noop;
  logic [7:0]        noop_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .op_set  (op_set),
    .idx     (idx),
    .clr_all (clr_all),
    .gnt     (gnt),
    .busy    (busy),
    .flags   (flags)
`ifdef NOOP_DETECT_EN
    ,
    .noop     (noop),
    .noop_cnt (noop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idx(input int r, input logic [FW-1:0] v);
    idx[r*FW +: FW] = v;
  endtask

  // S and R must never be asserted together on any cell.
  always @(negedge clk) begin
    n_assert++;
    assert ((dut.w_set & dut.w_rst) === '0) else begin
      n_fail++;
      $error("FAIL sr_exclusive: observed=%0h expected=0", dut.w_set & dut.w_rst);
    end
  end

  initial begin
    logic [NREQ-1:0] eg;
    reset   = 1'b0;
    req     = 4'b1111;
    op_set  = 4'b0000;
    idx     = '0;
    clr_all = 1'b0;

    // 1: reset held with all requests pending
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_flags", 32'(flags), 0);
    end
    reset = 1'b1;
    tick();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_busy", 32'(busy), 1);
    req = '0;
    tick();
    check("first_idle_gnt", 32'(gnt), 0);
    check("first_idle_busy", 32'(busy), 0);
    check("first_flags", 32'(flags), 0);

    // 2: single set then clear of flag 5 by requester 2
    req = 4'b0100; op_set = 4'b0100; set_idx(2, 3'd5);
    tick();
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_flags_pending", 32'(flags), 0);
    req = '0;
    tick();
    check("t2_flags_set", 32'(flags), 32'h20);
    check("t2_gnt_off", 32'(gnt), 0);
    req = 4'b0100; op_set = 4'b0000;
    tick();
    check("t2_gnt_clr", 32'(gnt), 32'h4);
    req = '0;
    tick();
    check("t2_flags_clr", 32'(flags), 0);

    // 3: round-robin from rr_ptr=0, requester i sets flag i
    reset = 1'b0; tick(); reset = 1'b1;
    req = 4'b1111; op_set = 4'b1111;
    for (int r = 0; r < 4; r++) set_idx(r, FW'(r));
    for (int k = 0; k < 4; k++) begin
      tick();
      eg = 4'b0001 << k;
      check("t3_rr_gnt", 32'(gnt), 32'(eg));
      req = req & ~eg;
      tick();
      check("t3_rr_gap", 32'(gnt), 0);
    end
    check("t3_flags", 32'(flags), 32'h0F);
    req = 4'b1001;
    tick();
    check("t3_gnt0", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    tick();
    check("t3_gnt3", 32'(gnt), 32'h8);
    req = '0;
    tick();

    // 4: contention on flag 3, set by req0 and clear by req1
    clr_all = 1'b1; tick(); clr_all = 1'b0;
    check("t4_cleared", 32'(flags), 0);
    req = 4'b0011; op_set = 4'b0001; set_idx(0, 3'd3); set_idx(1, 3'd3);
    tick();
    check("t4_gnt0", 32'(gnt), 32'h1);
    req = 4'b0010;
    tick();
    check("t4_flags_set", 32'(flags), 32'h08);
    tick();
    check("t4_gnt1", 32'(gnt), 32'h2);
    req = '0;
    tick();
    check("t4_flags_clr", 32'(flags), 0);

    // 5: fill flags 4..7 (rr_ptr=2), then clr_all during a set of flag 1
    req = 4'b1111; op_set = 4'b1111;
    for (int r = 0; r < 4; r++) set_idx(r, FW'(r + 4));
    for (int k = 0; k < 4; k++) begin
      tick();
      eg = 4'b0001 << ((k + 2) % 4);
      check("t5_fill_gnt", 32'(gnt), 32'(eg));
      req = req & ~eg;
      tick();
    end
    check("t5_flags_f0", 32'(flags), 32'hF0);
    req = 4'b0010; set_idx(1, 3'd1);
    tick();
    clr_all = 1'b1;
    check("t5_gnt", 32'(gnt), 32'h2);
    check("t5_busy", 32'(busy), 1);
`ifdef NOOP_DETECT_EN
    check("t5_noop_clr", 32'(noop), 1);
`endif
    req = '0;
    tick();
    clr_all = 1'b0;
    check("t5_flags", 32'(flags), 0);

`ifdef NOOP_DETECT_EN
    // 6: noop detection and saturation
    reset = 1'b0; tick(); reset = 1'b1;
    check("t6_cnt_rst", 32'(noop_cnt), 0);
    req = 4'b0001; op_set = 4'b0000; set_idx(0, 3'd0);
    tick();
    check("t6_noop", 32'(noop), 1);
    req = '0;
    tick();
    check("t6_cnt1", 32'(noop_cnt), 1);
    check("t6_noop_off", 32'(noop), 0);
    req = 4'b0001; op_set = 4'b0001;
    tick();
    check("t6_real_op", 32'(noop), 0);
    req = '0;
    tick();
    check("t6_cnt_hold", 32'(noop_cnt), 1);
    check("t6_flags", 32'(flags), 32'h01);
    for (int n = 0; n < 260; n++) begin
      req = 4'b0001;
      tick();
      req = '0;
      tick();
    end
    check("t6_cnt_sat", 32'(noop_cnt), 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
